// File: rtl/parking_session_ctrl.sv
// Request capture, round-robin arbitration and write sequencing for the three-car
// parking time/cost memory; also tracks slot occupancy and the last computed exit fee.
module parking_session_ctrl #(
    parameter logic [7:0] RATE = 8'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_entry_req,
    input  logic [2:0] i_exit_req,
    input  logic [9:0] i_time_now,
    input  logic [9:0] i_entry_time_rd,
    output logic [2:0] o_car_sel,
    output logic       o_write_entry,
    output logic       o_write_cost,
    output logic [9:0] o_entry_time_wr,
    output logic [9:0] o_cost_wr,
    output logic [2:0] o_occupied,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fee_valid,
    output logic [9:0] o_fee,
    output logic       o_err
);

    typedef enum logic [1:0] {StIdle, StEntryWr, StExitCalc, StExitWr} state_e;

    state_e     r_state;
    state_e     w_state_next;
    logic [2:0] r_entry_pend;
    logic [2:0] r_exit_pend;
    logic [2:0] r_occupied;
    logic [1:0] r_rr;
    logic [1:0] r_car;
    logic [9:0] r_cost;
    logic [9:0] r_fee;
    logic       r_err;

    logic [2:0]  w_elig;
    logic [2:0]  w_ill;
    logic [2:0]  w_rot;
    logic [1:0]  w_rot_sel;
    logic [1:0]  w_grant_idx;
    logic [2:0]  w_grant_oh;
    logic        w_grant_vld;
    logic [1:0]  w_drop_idx;
    logic [2:0]  w_drop_oh;
    logic        w_drop_vld;
    logic [2:0]  w_entry_clr;
    logic [2:0]  w_exit_clr;
    logic [2:0]  w_car_oh;
    logic [9:0]  w_dur;
    logic [17:0] w_prod;
    logic [9:0]  w_cost_sat;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // A car asks for the operation its occupancy allows; the other pending kind is illegal.
    assign w_elig = (r_occupied & r_exit_pend) | (~r_occupied & r_entry_pend);
    assign w_ill  = (r_occupied & r_entry_pend) | (~r_occupied & r_exit_pend);

    // Rotate eligibility so bit k means car (rr + k) mod 3.
    always_comb begin
        case (r_rr)
            2'd1:    w_rot = {w_elig[0], w_elig[2], w_elig[1]};
            2'd2:    w_rot = {w_elig[1], w_elig[0], w_elig[2]};
            default: w_rot = w_elig;
        endcase
        if (w_rot[0]) begin
            w_rot_sel = 2'd0;
        end else if (w_rot[1]) begin
            w_rot_sel = 2'd1;
        end else begin
            w_rot_sel = 2'd2;
        end
        if (w_ill[0]) begin
            w_drop_idx = 2'd0;
        end else if (w_ill[1]) begin
            w_drop_idx = 2'd1;
        end else begin
            w_drop_idx = 2'd2;
        end
    end

    assign w_grant_idx = mod3_add(r_rr, w_rot_sel);
    assign w_grant_oh  = 3'b001 << w_grant_idx;
    assign w_drop_oh   = 3'b001 << w_drop_idx;
    assign w_car_oh    = 3'b001 << r_car;
    assign w_grant_vld = (r_state == StIdle) && (|w_elig);
    assign w_drop_vld  = (r_state == StIdle) && !(|w_elig) && (|w_ill);

    always_comb begin
        w_entry_clr = 3'b000;
        w_exit_clr  = 3'b000;
        if (w_grant_vld) begin
            if (|(r_occupied & w_grant_oh)) begin
                w_exit_clr = w_grant_oh;
            end else begin
                w_entry_clr = w_grant_oh;
            end
        end else if (w_drop_vld) begin
            if (|(r_occupied & w_drop_oh)) begin
                w_entry_clr = w_drop_oh;
            end else begin
                w_exit_clr = w_drop_oh;
            end
        end
    end

    // Modular subtraction handles time_now wrapping past 1023.
    assign w_dur      = i_time_now - i_entry_time_rd;
    assign w_prod     = {8'd0, w_dur} * {10'd0, RATE};
    assign w_cost_sat = (|w_prod[17:10]) ? 10'h3FF : w_prod[9:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_vld) begin
                    w_state_next = (|(r_occupied & w_grant_oh)) ? StExitCalc : StEntryWr;
                end
            end
            StEntryWr:  w_state_next = StIdle;
            StExitCalc: w_state_next = StExitWr;
            StExitWr:   w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entry_pend <= 3'b000;
            r_exit_pend  <= 3'b000;
            r_occupied   <= 3'b000;
            r_rr         <= 2'd0;
            r_car        <= 2'd0;
            r_cost       <= 10'd0;
            r_fee        <= 10'd0;
            r_err        <= 1'b0;
        end else begin
            // A new request on the same edge as a clear wins.
            r_entry_pend <= (r_entry_pend & ~w_entry_clr) | i_entry_req;
            r_exit_pend  <= (r_exit_pend & ~w_exit_clr) | i_exit_req;
            r_err        <= w_drop_vld;
            if (w_grant_vld) begin
                r_car <= w_grant_idx;
                r_rr  <= mod3_add(w_grant_idx, 2'd1);
            end
            if (r_state == StEntryWr) begin
                r_occupied <= r_occupied | w_car_oh;
            end
            if (r_state == StExitCalc) begin
                r_cost <= w_cost_sat;
                r_fee  <= w_cost_sat;
            end
            if (r_state == StExitWr) begin
                r_occupied <= r_occupied & ~w_car_oh;
            end
        end
    end

    always_comb begin
        o_car_sel       = 3'b000;
        o_write_entry   = 1'b0;
        o_write_cost    = 1'b0;
        o_entry_time_wr = 10'd0;
        o_cost_wr       = 10'd0;
        o_done          = 1'b0;
        o_fee_valid     = 1'b0;
        o_busy          = (r_state != StIdle);
        o_occupied      = r_occupied;
        o_fee           = r_fee;
        o_err           = r_err;
        unique case (r_state)
            StEntryWr: begin
                o_car_sel       = w_car_oh;
                o_write_entry   = 1'b1;
                o_entry_time_wr = i_time_now;
                o_done          = 1'b1;
            end
            StExitCalc: begin
                o_car_sel = w_car_oh;
            end
            StExitWr: begin
                o_car_sel   = w_car_oh;
                o_write_cost = 1'b1;
                o_cost_wr   = r_cost;
                o_fee_valid = 1'b1;
                o_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_parking_session_ctrl.sv
// Random-stimulus bench for parking_session_ctrl: two instances (RATE 2 and 200) share
// stimulus and are compared every cycle against a transaction-level reference model.
module tb_parking_session_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] entry_req;
    logic [2:0] exit_req;
    logic [9:0] time_now;

    always #5 clk = ~clk;

    logic [2:0] car_sel_a, car_sel_b, occupied_a, occupied_b;
    logic       we_a, we_b, wc_a, wc_b, busy_a, busy_b, done_a, done_b;
    logic       fv_a, fv_b, err_a, err_b;
    logic [9:0] etw_a, etw_b, cw_a, cw_b, fee_a, fee_b, rd_a, rd_b;
    logic [9:0] mem_a [3];
    logic [9:0] mem_b [3];

    parking_session_ctrl #(.RATE(8'd2)) u_dut_a (
        .clk(clk), .reset(reset), .i_entry_req(entry_req), .i_exit_req(exit_req),
        .i_time_now(time_now), .i_entry_time_rd(rd_a), .o_car_sel(car_sel_a),
        .o_write_entry(we_a), .o_write_cost(wc_a), .o_entry_time_wr(etw_a),
        .o_cost_wr(cw_a), .o_occupied(occupied_a), .o_busy(busy_a), .o_done(done_a),
        .o_fee_valid(fv_a), .o_fee(fee_a), .o_err(err_a)
    );

    parking_session_ctrl #(.RATE(8'd200)) u_dut_b (
        .clk(clk), .reset(reset), .i_entry_req(entry_req), .i_exit_req(exit_req),
        .i_time_now(time_now), .i_entry_time_rd(rd_b), .o_car_sel(car_sel_b),
        .o_write_entry(we_b), .o_write_cost(wc_b), .o_entry_time_wr(etw_b),
        .o_cost_wr(cw_b), .o_occupied(occupied_b), .o_busy(busy_b), .o_done(done_b),
        .o_fee_valid(fv_b), .o_fee(fee_b), .o_err(err_b)
    );

    function automatic int oh2idx(input logic [2:0] oh);
        if (oh[1]) return 1;
        if (oh[2]) return 2;
        return 0;
    endfunction

    // Behavioural memory seen by each instance.
    assign rd_a = mem_a[oh2idx(car_sel_a)];
    assign rd_b = mem_b[oh2idx(car_sel_b)];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mem_a[i] <= 10'd0;
                mem_b[i] <= 10'd0;
            end
        end else begin
            if (we_a) mem_a[oh2idx(car_sel_a)] <= etw_a;
            if (we_b) mem_b[oh2idx(car_sel_b)] <= etw_b;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending sets, occupancy, and the one operation in flight.
    localparam int OpNone  = 0;
    localparam int OpEntry = 1;
    localparam int OpExit  = 2;

    int       rates [2] = '{2, 200};
    bit [2:0] m_entry_p, m_exit_p, m_occ;
    int       m_rr, m_op, m_car, m_phase;
    int       m_stamp [3];
    int       m_cost [2];
    int       m_fee [2];
    bit       m_err;

    task automatic model_reset();
        m_entry_p = 3'b000;
        m_exit_p  = 3'b000;
        m_occ     = 3'b000;
        m_rr      = 0;
        m_op      = OpNone;
        m_car     = 0;
        m_phase   = 0;
        m_err     = 1'b0;
        for (int i = 0; i < 3; i++) m_stamp[i] = 0;
        for (int r = 0; r < 2; r++) begin
            m_cost[r] = 0;
            m_fee[r]  = 0;
        end
    endtask

    task automatic model_step();
        int  g;
        int  dur;
        int  c;
        bit  drop;
        drop = 1'b0;
        if (m_op == OpNone) begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_rr + k) % 3;
                if (g < 0 && (m_occ[i] ? m_exit_p[i] : m_entry_p[i])) g = i;
            end
            if (g >= 0) begin
                if (m_occ[g]) begin
                    m_op = OpExit;
                    m_exit_p[g] = 1'b0;
                end else begin
                    m_op = OpEntry;
                    m_entry_p[g] = 1'b0;
                end
                m_car   = g;
                m_phase = 0;
                m_rr    = (g + 1) % 3;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!drop && m_occ[i] && m_entry_p[i]) begin
                        m_entry_p[i] = 1'b0;
                        drop = 1'b1;
                    end else if (!drop && !m_occ[i] && m_exit_p[i]) begin
                        m_exit_p[i] = 1'b0;
                        drop = 1'b1;
                    end
                end
            end
        end else if (m_op == OpEntry) begin
            m_stamp[m_car] = int'(time_now);
            m_occ[m_car]   = 1'b1;
            m_op           = OpNone;
        end else if (m_phase == 0) begin
            dur = (int'(time_now) + 1024 - m_stamp[m_car]) % 1024;
            for (int r = 0; r < 2; r++) begin
                c = dur * rates[r];
                if (c > 1023) c = 1023;
                m_cost[r] = c;
                m_fee[r]  = c;
            end
            m_phase = 1;
        end else begin
            m_occ[m_car] = 1'b0;
            m_op         = OpNone;
        end
        m_err     = drop;
        m_entry_p = m_entry_p | entry_req;
        m_exit_p  = m_exit_p | exit_req;
    endtask

    task automatic check_outputs();
        int e_sel, e_we, e_wc, e_etw;
        e_we  = (m_op == OpEntry) ? 1 : 0;
        e_wc  = (m_op == OpExit && m_phase == 1) ? 1 : 0;
        e_sel = (m_op != OpNone) ? (1 << m_car) : 0;
        e_etw = e_we ? int'(time_now) : 0;
        check_eq("a car_sel", car_sel_a, e_sel);
        check_eq("a write_entry", we_a, e_we);
        check_eq("a write_cost", wc_a, e_wc);
        check_eq("a entry_time_wr", etw_a, e_etw);
        check_eq("a cost_wr", cw_a, e_wc ? m_cost[0] : 0);
        check_eq("a occupied", occupied_a, m_occ);
        check_eq("a busy", busy_a, (m_op != OpNone) ? 1 : 0);
        check_eq("a done", done_a, e_we | e_wc);
        check_eq("a fee_valid", fv_a, e_wc);
        check_eq("a fee", fee_a, m_fee[0]);
        check_eq("a err", err_a, m_err);
        check_eq("b car_sel", car_sel_b, e_sel);
        check_eq("b write_entry", we_b, e_we);
        check_eq("b write_cost", wc_b, e_wc);
        check_eq("b entry_time_wr", etw_b, e_etw);
        check_eq("b cost_wr", cw_b, e_wc ? m_cost[1] : 0);
        check_eq("b occupied", occupied_b, m_occ);
        check_eq("b busy", busy_b, (m_op != OpNone) ? 1 : 0);
        check_eq("b done", done_b, e_we | e_wc);
        check_eq("b fee_valid", fv_b, e_wc);
        check_eq("b fee", fee_b, m_fee[1]);
        check_eq("b err", err_b, m_err);
    endtask

    initial begin
        reset     = 1'b1;
        entry_req = 3'b000;
        exit_req  = 3'b000;
        time_now  = 10'd0;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 2) begin
                reset = 1'b1;
            end else if (cyc < 10) begin
                reset = 1'b0;
            end else begin
                reset = (m_op == OpExit && m_phase == 0 && $urandom_range(0, 5) == 0) ||
                        ($urandom_range(0, 299) == 0);
            end
            if (cyc == 2) begin
                entry_req = 3'b111;
                exit_req  = 3'b000;
            end else if (cyc < 10) begin
                entry_req = 3'b000;
                exit_req  = 3'b000;
            end else begin
                entry_req = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) &
                            3'($urandom_range(0, 7));
                exit_req  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)) &
                            3'($urandom_range(0, 7));
            end
            time_now = 10'($urandom_range(0, 1023));
            #1;
            if (reset) model_reset();
            check_outputs();
            if (!reset) model_step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
